// File: rtl/master_arbiter_pkg.sv
// master_arbiter_pkg: shared state encoding, bus width and forced-completion data
package master_arbiter_pkg;
  localparam int BUS_W = 16;
  localparam logic [BUS_W-1:0] TIMEOUT_DAT = 16'hDEAD;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT_CPU = 2'b01;
  localparam logic [1:0] ST_GNT_UART = 2'b10;
  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    GNT_CPU  = ST_GNT_CPU,
    GNT_UART = ST_GNT_UART
  } state_e;
endpackage

// File: rtl/master_arbiter_timeout_counter.sv
// arb_timeout_counter: counts granted cycles without completion, flags the last allowed cycle
module arb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_run,
  output logic o_tc
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = i_run ? cnt_q + 8'd1 : 8'd0;
  assign o_tc = cnt_q == 8'(TIMEOUT - 1);
  // count register; returns to 0 whenever the grant ends or is about to start
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/master_arbiter.sv
// master_arbiter: two-master (CPU, UART) shared-bus arbiter with grant timeout; MASTER_ARBITER_RR_EN selects round-robin ties
module master_arbiter
  import master_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cpu_cs,
  input  logic             i_cpu_we,
  input  logic [BUS_W-1:0] i_cpu_addr,
  input  logic [BUS_W-1:0] i_cpu_dat,
  output logic [BUS_W-1:0] o_cpu_dat,
  output logic             o_cpu_ack,
  input  logic             i_uart_cs,
  input  logic             i_uart_we,
  input  logic [BUS_W-1:0] i_uart_addr,
  input  logic [BUS_W-1:0] i_uart_dat,
  output logic [BUS_W-1:0] o_uart_dat,
  output logic             o_uart_ack,
  output logic             o_slave_cs,
  output logic             o_slave_we,
  output logic [BUS_W-1:0] o_slave_addr,
  output logic [BUS_W-1:0] o_slave_dat,
  input  logic [BUS_W-1:0] i_slave_dat,
  input  logic             i_slave_ack,
  output logic [1:0]       o_grant,
  output logic             o_timeout,
  input  logic             i_timeout_clr
);
  state_e state_q, state_d;
  logic gc, gu, req, tc, to_evt, tie_uart, timeout_q, timeout_d;
  assign gc = state_q == GNT_CPU;
  assign gu = state_q == GNT_UART;
  assign req = gc ? i_cpu_cs : gu ? i_uart_cs : 1'b0;
  assign to_evt = req && tc && !i_slave_ack;
`ifdef MASTER_ARBITER_RR_EN
  logic last_uart_q, last_uart_d;
  assign tie_uart = !last_uart_q;
  assign last_uart_d = (state_q == IDLE && state_d != IDLE) ? state_d == GNT_UART : last_uart_q;
  // last owner, starting as CPU so the first tie goes to UART
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) last_uart_q <= 1'b0;
    else last_uart_q <= last_uart_d;
`else
  assign tie_uart = 1'b1;
`endif
  // next state: pick an owner from IDLE, release on ack, drop or timeout
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (i_cpu_cs && i_uart_cs) ? (tie_uart ? GNT_UART : GNT_CPU) :
                i_cpu_cs ? GNT_CPU : i_uart_cs ? GNT_UART : IDLE;
    else if (!req || i_slave_ack || tc)
      state_d = IDLE;
  end
  // state register; o_grant is the one-hot state encoding
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state_q <= IDLE;
    else state_q <= state_d;
  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_run    (state_q != IDLE && state_d == state_q),
    .o_tc     (tc)
  );
  assign timeout_d = to_evt ? 1'b1 : i_timeout_clr ? 1'b0 : timeout_q;
  // sticky timeout flag; a new timeout beats a same-cycle clear
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) timeout_q <= 1'b0;
    else timeout_q <= timeout_d;
  assign o_timeout = timeout_q;
  assign o_grant = state_q;
  assign o_slave_cs = req;
  assign o_slave_we = gc ? i_cpu_we : gu ? i_uart_we : 1'b0;
  assign o_slave_addr = gc ? i_cpu_addr : gu ? i_uart_addr : '0;
  assign o_slave_dat = gc ? i_cpu_dat : gu ? i_uart_dat : '0;
  assign o_cpu_ack = gc && (i_slave_ack || to_evt);
  assign o_uart_ack = gu && (i_slave_ack || to_evt);
  assign o_cpu_dat = (gc && to_evt) ? TIMEOUT_DAT : i_slave_dat;
  assign o_uart_dat = (gu && to_evt) ? TIMEOUT_DAT : i_slave_dat;
endmodule

// File: tb/tb_master_arbiter.sv
// tb_master_arbiter: directed bench for master_arbiter with TIMEOUT=8
module tb_master_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_cs = 0, cpu_we = 0, uart_cs = 0, uart_we = 0, slave_ack = 0, to_clr = 0;
  logic [15:0] cpu_addr = 0, cpu_wdat = 0, uart_addr = 0, uart_wdat = 0, slave_rdat = 0;
  logic [15:0] cpu_rdat, uart_rdat, s_addr, s_dat;
  logic cpu_ack, uart_ack, s_cs, s_we, tmo;
  logic [1:0] grant, tie2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  master_arbiter #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_dat(cpu_wdat),
    .o_cpu_dat(cpu_rdat), .o_cpu_ack(cpu_ack),
    .i_uart_cs(uart_cs), .i_uart_we(uart_we), .i_uart_addr(uart_addr), .i_uart_dat(uart_wdat),
    .o_uart_dat(uart_rdat), .o_uart_ack(uart_ack),
    .o_slave_cs(s_cs), .o_slave_we(s_we), .o_slave_addr(s_addr), .o_slave_dat(s_dat),
    .i_slave_dat(slave_rdat), .i_slave_ack(slave_ack),
    .o_grant(grant), .o_timeout(tmo), .i_timeout_clr(to_clr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MASTER_ARBITER_RR_EN
    tie2 = 2'b01;
`else
    tie2 = 2'b10;
`endif
    #3;
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_tmo", 16'(tmo), 16'h0);
    chk("rst_scs", 16'(s_cs), 16'h0);
    chk("rst_acks", 16'({cpu_ack, uart_ack}), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    // CPU read, slave acks one cycle after cs
    tick; cpu_cs = 1; cpu_addr = 16'h0010; slave_rdat = 16'h1234; #1;
    chk("rd_c0_grant", 16'(grant), 16'h0);
    chk("rd_c0_scs", 16'(s_cs), 16'h0);
    tick; #1;
    chk("rd_c1_grant", 16'(grant), 16'h1);
    chk("rd_c1_scs", 16'(s_cs), 16'h1);
    chk("rd_c1_addr", s_addr, 16'h0010);
    chk("rd_c1_ack", 16'(cpu_ack), 16'h0);
    tick; slave_ack = 1; #1;
    chk("rd_c2_ack", 16'(cpu_ack), 16'h1);
    chk("rd_c2_dat", cpu_rdat, 16'h1234);
    chk("rd_c2_uack", 16'(uart_ack), 16'h0);
    tick; slave_ack = 0; cpu_cs = 0; #1;
    chk("rd_c3_idle", 16'(grant), 16'h0);
    // both masters requesting continuously
    tick; cpu_cs = 1; uart_cs = 1; #1;
    tick; slave_ack = 1; #1;
    chk("tie1_grant", 16'(grant), 16'h2);
    chk("tie1_uack", 16'(uart_ack), 16'h1);
    chk("tie1_cack", 16'(cpu_ack), 16'h0);
    tick; slave_ack = 0; #1;
    chk("tie1_gap", 16'(grant), 16'h0);
    tick; slave_ack = 1; #1;
    chk("tie2_grant", 16'(grant), 16'(tie2));
    tick; slave_ack = 0; #1;
    tick; slave_ack = 1; #1;
    chk("tie3_grant", 16'(grant), 16'h2);
    tick; slave_ack = 0; cpu_cs = 0; uart_cs = 0; #1;
    chk("tie_end", 16'(grant), 16'h0);
    // CPU write with no slave ack: forced completion in 8th grant cycle, clear in same cycle loses
    tick; cpu_cs = 1; cpu_we = 1; cpu_wdat = 16'hBEEF; #1;
    tick; #1;
    chk("to_we", 16'(s_we), 16'h1);
    chk("to_wdat", s_dat, 16'hBEEF);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("to_noack%0d", k), 16'(cpu_ack), 16'h0);
      tick;
    end
    to_clr = 1; #1;
    chk("to_ack", 16'(cpu_ack), 16'h1);
    chk("to_dead", cpu_rdat, 16'hDEAD);
    chk("to_flag_pre", 16'(tmo), 16'h0);
    tick; to_clr = 0; cpu_cs = 0; cpu_we = 0; #1;
    chk("to_flag", 16'(tmo), 16'h1);
    chk("to_idle", 16'(grant), 16'h0);
    tick; #1;
    chk("to_sticky", 16'(tmo), 16'h1);
    to_clr = 1;
    tick; to_clr = 0; #1;
    chk("to_clr", 16'(tmo), 16'h0);
    // ack on the terminal-count cycle completes normally
    cpu_cs = 1; slave_rdat = 16'h5555;
    tick; #1;
    for (int k = 1; k < 8; k++) tick;
    slave_ack = 1; #1;
    chk("tc_ack", 16'(cpu_ack), 16'h1);
    chk("tc_dat", cpu_rdat, 16'h5555);
    tick; slave_ack = 0; cpu_cs = 0; #1;
    chk("tc_notmo", 16'(tmo), 16'h0);
    // UART drops cs in its third cycle
    tick; uart_cs = 1; #1;
    tick; #1;
    chk("drop_c1", 16'(grant), 16'h2);
    tick;
    tick; uart_cs = 0; #1;
    chk("drop_c3_ack", 16'(uart_ack), 16'h0);
    tick; #1;
    chk("drop_c4_grant", 16'(grant), 16'h0);
    chk("drop_tmo", 16'(tmo), 16'h0);
    // asynchronous reset in the middle of a grant
    cpu_cs = 1;
    tick; #1;
    chk("ar_grant", 16'(grant), 16'h1);
    #1 rst_n = 0; #1;
    chk("ar_scs", 16'(s_cs), 16'h0);
    chk("ar_grant0", 16'(grant), 16'h0);
    chk("ar_ack", 16'(cpu_ack), 16'h0);
    @(negedge clk) rst_n = 1;
    tick; #1;
    chk("ar_regrant", 16'(grant), 16'h1);
    cpu_cs = 0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/master_arbiter.md
MASTER_ARBITER -- requirements
Module: master_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, range 2..255: grant cycles allowed without slave ack before forced completion.
REQ-002 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_cpu_cs, i_cpu_we  in  1 each  CPU master request, held until ack; write enable.
REQ-005 i_cpu_addr, i_cpu_dat  in  16 each  CPU address, write data.
REQ-006 o_cpu_dat  out  16  read data to CPU.
REQ-007 o_cpu_ack  out  1  one-cycle completion to CPU.
REQ-008 i_uart_cs, i_uart_we  in  1 each  UART bridge master request, write enable.
REQ-009 i_uart_addr, i_uart_dat  in  16 each  UART master address, write data.
REQ-010 o_uart_dat  out  16  read data to UART master.
REQ-011 o_uart_ack  out  1  one-cycle completion to UART master.
REQ-012 o_slave_cs, o_slave_we  out  1 each  shared bus request, write enable.
REQ-013 o_slave_addr, o_slave_dat  out  16 each  shared bus address, write data.
REQ-014 i_slave_dat  in  16  shared bus read data; i_slave_ack  in  1  shared bus completion.
REQ-015 o_grant  out  2  one-hot current owner: bit0 CPU, bit1 UART; 00 idle.
REQ-016 o_timeout  out  1  sticky timeout flag; i_timeout_clr  in  1  clears it synchronously.

Function
REQ-017 FSM states IDLE, GNT_CPU, GNT_UART; state register drives o_grant.
REQ-018 IDLE: any cs high -> registered grant next cycle; no request -> stay IDLE.
REQ-019 Both cs high in IDLE -> winner per REQ-030/031.
REQ-020 While granted, o_slave_cs/we/addr/dat = granted master's inputs combinationally; IDLE -> all 0.
REQ-021 o_cpu_dat and o_uart_dat = i_slave_dat always, except forced completion (REQ-024).
REQ-022 o_x_ack = i_slave_ack AND x granted, same cycle; non-granted master never acked.
REQ-023 Slave ack while granted -> IDLE next cycle; one idle cycle between transactions (ack cycle N, new grant cycle N+2 earliest).
REQ-024 8-bit grant counter: 0 on grant entry, +1 per granted cycle without ack; at TIMEOUT-1 with no ack: ack granted master that cycle, its o_dat = 16'hDEAD, set o_timeout, -> IDLE.
REQ-025 Slave ack coinciding with counter at TIMEOUT-1 -> normal completion, no timeout.
REQ-026 Granted master drops cs before ack -> IDLE next cycle, no ack, o_timeout unchanged.
REQ-027 i_timeout_clr and timeout in same cycle -> o_timeout set (set wins).
REQ-028 Minimum latency: cs at cycle 0, o_slave_cs cycle 1, registered slave ack cycle 2 -> master ack cycle 2.

Reset
REQ-029 i_reset_n low: immediately state IDLE, counter 0, o_timeout 0, o_grant 00, last-owner = CPU; all acks and o_slave_cs 0; mid-transaction reset drops transfer with no ack.

Configuration
REQ-030 MASTER_ARBITER_RR_EN defined: round-robin; tie goes to master not granted last; last-owner updated on every grant.
REQ-031 MASTER_ARBITER_RR_EN undefined: fixed priority, UART always wins a tie; last-owner register absent.

Structure
REQ-032 Shared package holds state encoding constants, 16'hDEAD timeout data constant, bus width 16.
REQ-033 One sub-module, arb_timeout_counter (counter plus terminal-count compare); otherwise flat.

Verification
REQ-034 CPU read only, slave acks one cycle after cs, i_slave_dat=16'h1234 -> o_cpu_ack cycle 2, o_cpu_dat=16'h1234, o_uart_ack 0.
REQ-035 Both cs high from reset, RR_EN defined -> UART granted first, then CPU, then UART; RR_EN undefined -> UART granted every tie.
REQ-036 TIMEOUT=8, slave never acks, CPU write -> o_cpu_ack in 8th grant cycle, o_cpu_dat=16'hDEAD, o_timeout=1 until i_timeout_clr pulse.
REQ-037 UART granted, i_uart_cs dropped cycle 3 -> o_grant=00 cycle 4, no ack, o_timeout stays 0.
REQ-038 i_reset_n low mid-grant -> o_slave_cs and o_grant 0 same cycle without clock; after release, pending CPU cs granted next edge.
